// File: rtl/siggit_decim.sv
// Sinc^3 CIC decimator that turns the siggit 1-bit sigma-delta stream back into
// signed 16-bit samples, with saturation flag on the scaled comb output.
module siggit_decim #(
  parameter int DECIM = 64,
  parameter int LOG2D = 6
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BITSTREAM,
  input  logic               BIT_EN,
  output logic signed [15:0] OUTVAL,
  output logic               OUT_VALID,
  output logic               SAT
);

  localparam int W     = 2 + 3 * LOG2D;
  localparam int SHIFT = 3 * LOG2D - 15;

  logic [LOG2D-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0]       d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [W-1:0]       c3_q, c3_d;
  logic               strobe_q, strobe_d;
  logic               comb_vld_q, comb_vld_d;
  logic signed [15:0] outval_q, outval_d;
  logic               out_valid_q, out_valid_d;
  logic               sat_q, sat_d;

  logic [W-1:0]        x;
  logic [W-1:0]        c1, c2, c3;
  logic signed [W-1:0] scaled;
  logic [W-16:0]       scaled_hi;

  // NOTE: every *_d gets its hold value first, so no path through this block
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    i3_d        = i3_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    c3_d        = c3_q;
    strobe_d    = 1'b0;
    comb_vld_d  = 1'b0;
    outval_d    = outval_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;

    // Bit 1 maps to +1, bit 0 to -1 (all ones in two's complement).
    x = BITSTREAM ? W'(1) : '1;

    if (BIT_EN) begin
      i1_d     = i1_q + x;
      i2_d     = i2_q + i1_q;
      i3_d     = i3_q + i2_q;
      cnt_d    = cnt_q + 1'b1;
      strobe_d = (cnt_q == LOG2D'(DECIM - 1));
    end

    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
    if (strobe_q) begin
      d1_d       = i3_q;
      d2_d       = c1;
      d3_d       = c2;
      c3_d       = c3;
      comb_vld_d = 1'b1;
    end

    // In range exactly when every bit above bit 15 matches the sign bit.
    scaled    = $signed(c3_q) >>> SHIFT;
    scaled_hi = scaled[W-1:15];
    if (comb_vld_q) begin
      out_valid_d = 1'b1;
      if ((&scaled_hi) || !(|scaled_hi)) begin
        outval_d = scaled[15:0];
        sat_d    = 1'b0;
      end else begin
        outval_d = scaled[W-1] ? 16'sh8000 : 16'sh7fff;
        sat_d    = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, which the pipelined integrator cascade relies on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      c3_q        <= '0;
      strobe_q    <= 1'b0;
      comb_vld_q  <= 1'b0;
      outval_q    <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      c3_q        <= c3_d;
      strobe_q    <= strobe_d;
      comb_vld_q  <= comb_vld_d;
      outval_q    <= outval_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign OUTVAL    = outval_q;
  assign OUT_VALID = out_valid_q;
  assign SAT       = sat_q;

endmodule

// File: tb/tb_siggit_decim.sv
// Directed bench for siggit_decim at DECIM=64: steady-state values, pulse timing,
// BIT_EN gaps, reset mid-frame and mid-pipeline, and a first-order loopback source.
module tb_siggit_decim;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               BITSTREAM = 1'b0;
  logic               BIT_EN = 1'b0;
  logic signed [15:0] OUTVAL;
  logic               OUT_VALID;
  logic               SAT;

  siggit_decim #(.DECIM(64), .LOG2D(6)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BITSTREAM (BITSTREAM),
    .BIT_EN    (BIT_EN),
    .OUTVAL    (OUTVAL),
    .OUT_VALID (OUT_VALID),
    .SAT       (SAT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  int       cycle = 0;
  int       strobe_cnt = 0;
  int       phase = 0;
  int       bit_idx = 0;
  int       en_period = 1;
  logic [3:0] pat = 4'b0001;
  int       plen = 1;
  bit       loopback = 1'b0;
  int       sd_acc = 0;
  int       sd_in = 0;
  bit       rst_req = 1'b0;
  bit       rst_seen = 1'b0;
  bit       armed = 1'b0;
  int       rst_edge = 0;
  bit       last_en = 1'b0;

  // Observation log
  logic               prev_valid = 1'b0;
  logic signed [15:0] held = '0;
  int                 dbl = 0;
  int                 hold_err = 0;
  int                 pulse_edge[$];
  logic signed [15:0] pulse_val[$];
  logic               pulse_sat[$];
  int                 frame_edge[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    pulse_edge.delete();
    pulse_val.delete();
    pulse_sat.delete();
    frame_edge.delete();
  endtask

  // One cycle: observe the state left by the last rising edge, then drive the
  // inputs for the next one.
  task automatic tick();
    bit b;
    bit en;
    @(negedge CLK);
    cycle++;
    if (rst_seen) begin
      rst_seen   = 1'b0;
      armed      = 1'b1;
      held       = OUTVAL;
      prev_valid = OUT_VALID;
    end else if (armed) begin
      if (OUT_VALID === 1'b1) begin
        pulse_edge.push_back(cycle);
        pulse_val.push_back(OUTVAL);
        pulse_sat.push_back(SAT);
        if (prev_valid === 1'b1) dbl++;
        held = OUTVAL;
      end else if (OUTVAL !== held) begin
        hold_err++;
      end
      prev_valid = OUT_VALID;
    end

    if (rst_req) begin
      RESET      = 1'b1;
      BIT_EN     = 1'b1;
      BITSTREAM  = 1'b1;
      rst_req    = 1'b0;
      rst_seen   = 1'b1;
      rst_edge   = cycle + 1;
      strobe_cnt = 0;
      phase      = 0;
      bit_idx    = 0;
      last_en    = 1'b0;
      clear_log();
    end else begin
      RESET = 1'b0;
      en    = ((phase % en_period) == 0);
      phase++;
      BIT_EN = en;
      if (en) begin
        if (loopback) begin
          b = (sd_acc >= 0);
          sd_acc = sd_acc + sd_in - (b ? 32768 : -32768);
        end else begin
          b = pat[bit_idx % plen];
        end
        bit_idx++;
        BITSTREAM = b;
        strobe_cnt++;
        if ((strobe_cnt % 64) == 0) frame_edge.push_back(cycle + 1);
      end else begin
        BITSTREAM = 1'($urandom_range(0, 1));
      end
      last_en = en;
    end
  endtask

  task automatic restart();
    rst_req = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (pulse_val.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_pulses"}, pulse_val.size(), n);
  endtask

  initial begin
    int k;
    int d;

    // Reset state
    restart();
    check("rst_outval", OUTVAL, 0);
    check("rst_valid", OUT_VALID, 0);
    check("rst_sat", SAT, 0);

    // All ones: full scale clips to +32767 with SAT, 64-cycle spacing
    pat = 4'b0001; plen = 1; en_period = 1;
    restart();
    run_until(4, 400, "ones");
    check("ones_val2", pulse_val[2], 32767);
    check("ones_sat2", pulse_sat[2], 1);
    check("ones_val3", pulse_val[3], 32767);
    check("ones_sat3", pulse_sat[3], 1);
    check("ones_spacing", pulse_edge[3] - pulse_edge[2], 64);
    check("ones_latency", pulse_edge[0] - frame_edge[0], 2);

    // All zeros: negative full scale is representable, no SAT
    pat = 4'b0000; plen = 1;
    restart();
    run_until(4, 400, "zeros");
    check("zeros_val2", pulse_val[2], -32768);
    check("zeros_sat2", pulse_sat[2], 0);
    check("zeros_val3", pulse_val[3], -32768);

    // Alternating 1,0 averages to zero
    pat = 4'b0101; plen = 2;
    restart();
    run_until(4, 400, "alt");
    check("alt_val2", pulse_val[2], 0);
    check("alt_val3", pulse_val[3], 0);
    check("alt_sat3", pulse_sat[3], 0);

    // 1,1,1,0 averages to +0.5 -> C3 = 2^17, >>> 3 = 16384
    pat = 4'b0111; plen = 4;
    restart();
    run_until(4, 400, "p1110");
    check("p1110_val2", pulse_val[2], 16384);
    check("p1110_val3", pulse_val[3], 16384);
    check("p1110_sat3", pulse_sat[3], 0);

    // Same pattern with BIT_EN every third cycle
    en_period = 3;
    restart();
    run_until(5, 1200, "gap");
    check("gap_val2", pulse_val[2], 16384);
    check("gap_val3", pulse_val[3], 16384);
    check("gap_val4", pulse_val[4], 16384);
    check("gap_spacing", pulse_edge[4] - pulse_edge[3], 192);
    check("gap_latency", pulse_edge[2] - frame_edge[2], 2);
    en_period = 1;

    // Reset at bit 30 of a frame while outputs hold a clipped value
    pat = 4'b0001; plen = 1;
    restart();
    run_until(3, 400, "rsta_pre");
    k = 0;
    while ((strobe_cnt % 64) != 30 && k < 200) begin
      tick();
      k++;
    end
    check("rsta_pre_val", OUTVAL, 32767);
    rst_req = 1'b1;
    tick();
    tick();
    check("rsta_outval", OUTVAL, 0);
    check("rsta_sat", SAT, 0);
    check("rsta_valid", OUT_VALID, 0);
    run_until(1, 200, "rsta_post");
    check("rsta_first_pulse", pulse_edge[0] - rst_edge, 66);

    // Reset one cycle after a frame-completing strobe drops the pending result
    run_until(3, 400, "rstb_pre");
    k = 0;
    do begin
      tick();
      k++;
    end while (!(last_en && (strobe_cnt % 64) == 0 && strobe_cnt > 0) && k < 200);
    rst_req = 1'b1;
    tick();
    tick();
    check("rstb_outval", OUTVAL, 0);
    check("rstb_sat", SAT, 0);
    tick();
    check("rstb_pend_valid", OUT_VALID, 0);
    check("rstb_no_pulse", pulse_val.size(), 0);
    run_until(1, 200, "rstb_post");
    check("rstb_first_pulse", pulse_edge[0] - rst_edge, 66);

    // Loopback from a first-order modulator, +0x4000 then 0xC000 (-16384)
    loopback = 1'b1;
    sd_acc = 0;
    sd_in = 16384;
    restart();
    run_until(5, 600, "lbp");
    d = pulse_val[3] - 16384;
    check("lbp_in_range3", (d >= -64 && d <= 64), 1);
    d = pulse_val[4] - 16384;
    check("lbp_in_range4", (d >= -64 && d <= 64), 1);
    sd_in = -16384;
    clear_log();
    run_until(5, 600, "lbn");
    d = pulse_val[3] + 16384;
    check("lbn_in_range3", (d >= -64 && d <= 64), 1);
    d = pulse_val[4] + 16384;
    check("lbn_in_range4", (d >= -64 && d <= 64), 1);
    loopback = 1'b0;

    // Pulse width and output hold across the whole run
    check("single_cycle_pulse", dbl, 0);
    check("hold_between_pulses", hold_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
